stopwatch_scan_driver: RTL and testbench
========================================

Name: stopwatch_scan_driver

Overview:
- Parametrised stopwatch core with an NUM_DIGITS-digit BCD counter, internal tick and refresh prescalers, start/stop and lap-hold control, and a time-multiplexed 7-segment scan output.
- Replaces the fixed 4-digit driver plus its separate divider, counter and digit-enable blocks with one self-contained block.
- Adds leading-zero blanking, a sticky overflow flag and a lap freeze.
- Sits directly between the debounced board buttons and the seven-segment pins.

Parameters:
- NUM_DIGITS, 4, number of BCD digits counted and scanned (2..8).
- TICK_DIV, 1000000, clk cycles per count increment (10 ms at 100 MHz); minimum 2.
- REFRESH_DIV, 100000, clk cycles per digit scan slot; minimum 2.
- DP_POS, 2, digit index whose decimal point is lit (0 = LSD).
- BLANK_LZ, 1, 1 = blank leading zeros above DP_POS, 0 = show all digits.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, synchronous active-low reset.
- start, input, 1, debounced start/stop button level; a rising edge toggles run.
- lap, input, 1, debounced lap button level; a rising edge toggles display hold.
- seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
- decimal, output, 1, decimal point, active-low.
- an, output, NUM_DIGITS, digit enables, active-low, one-cold; bit 0 = LSD.
- running, output, 1, current run state.
- overflow, output, 1, sticky; set when the counter wraps.

Behaviour:
- Reset (reset==0 at a clk edge) sets: run=0, hold=0, count=0, snapshot=0, overflow=0, prescalers=0, scan index=0, start/lap edge registers=0, seg=7'h7F, decimal=1, an=all ones.
- Edge detect: start_q and lap_q register the inputs. A rising edge is input & ~input_q. A held button produces exactly one edge.
- Start edge: run toggles and the tick prescaler clears to 0. No increment occurs in that cycle, even if the prescaler was at terminal count.
- Tick prescaler: counts 0..TICK_DIV-1 only while run=1 and holds while run=0. An increment happens in the cycle where run=1 and the prescaler equals TICK_DIV-1. The first increment after a start edge therefore lands exactly TICK_DIV cycles after that edge.
- Counter: NUM_DIGITS cascaded BCD digits, each 0..9, with ripple carry within the same cycle.
- Wrap: all digits at 9 plus an increment gives all digits 0 and sets overflow=1. overflow stays set until reset.
- Lap edge while run=1 and hold=0: snapshot <= count (value before any same-cycle increment) and hold=1.
- Lap edge while hold=1: hold=0, regardless of run.
- Lap edge while run=0 and hold=0: ignored.
- Start and lap edges in the same cycle: both are applied per the rules above, evaluated against pre-edge run/hold.
- Counting continues during hold. Stopping does not clear hold.
- Display source: snapshot when hold=1, else count.
- Scan prescaler: free-running 0..REFRESH_DIV-1. At terminal count, index advances and wraps from NUM_DIGITS-1 to 0.
- Blanking (BLANK_LZ=1): digit i>DP_POS is blank if it and every digit above it are 0. Digits <= DP_POS are never blanked.
- Output register, one-cycle latency from index/display source to pins:
  - an = ~(1<<index).
  - seg = 7'h7F if blank, else the active-low pattern for 0-9 (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10).
  - decimal = 0 if index==DP_POS, else 1.
- running is a combinational copy of run. There are no other combinational input-to-output paths.

Test Plan (NUM_DIGITS=4, TICK_DIV=4, REFRESH_DIV=2, DP_POS=2, BLANK_LZ=1):
- Reset held 3 cycles then released -> an=4'hF, seg=7'h7F, decimal=1 while in reset. After release, an cycles 1110,1101,1011,0111 every 2 clks. Display shows 0.00 with digit 3 blank; decimal is 0 only on an=1011.
- Start held high for 10 cycles -> one toggle only; running=1. Count reaches 0001 exactly 4 cycles after the edge and 0003 after 12 cycles. A second start pulse stops the count at the value shown, with no extra increment.
- Run to count 0099, then wait one tick -> 0100. Digit 3 becomes visible at count 1000 and digit 3 shows 1 (seg 7'h79).
- Preload by running to 9999, then wait one tick -> count 0000 and overflow=1. overflow stays 1 through further ticks and a stop/start, and clears only on reset.
- Lap at count 0042 while running -> display frozen at 0.42 while the internal count advances. Second lap -> display jumps to the live count. A lap pulse while stopped with hold=0 has no effect.
- Start and lap edges in the same cycle while run=1 -> run=0, hold=1, snapshot equals the pre-edge count. Reset asserted mid-run -> all state returns to its reset values on the next edge.

Source files
------------

// File: rtl/stopwatch_scan_driver.sv
// Stopwatch core: BCD counter with tick prescaler, start/stop and lap hold,
// leading-zero blanking, sticky overflow and a multiplexed 7-segment scan.
module stopwatch_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 1000000,
  parameter int REFRESH_DIV = 100000,
  parameter int DP_POS      = 2,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  lap,
  output logic [6:0]            seg,
  output logic                  decimal,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  running,
  output logic                  overflow
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] DP_IDX    = IW'(DP_POS);

  logic                       r_start_q;
  logic                       r_lap_q;
  logic                       r_run;
  logic                       r_hold;
  logic                       r_ovf;
  logic [TW-1:0]              r_tick;
  logic [RW-1:0]              r_ref;
  logic [IW-1:0]              r_idx;
  logic [NUM_DIGITS-1:0][3:0] r_count;
  logic [NUM_DIGITS-1:0][3:0] r_snap;
  logic [6:0]                 r_seg;
  logic                       r_dp;
  logic [NUM_DIGITS-1:0]      r_an;

  logic                       w_start_edge;
  logic                       w_lap_edge;
  logic                       w_inc;
  logic                       w_carry;
  logic                       w_wrap;
  logic                       w_lz;
  logic [NUM_DIGITS-1:0][3:0] w_count_nxt;
  logic [NUM_DIGITS-1:0][3:0] w_disp;
  logic [NUM_DIGITS-1:0]      w_blank;
  logic [3:0]                 w_digit;
  logic                       w_blank_sel;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h40;
      4'd1:    f_seg = 7'h79;
      4'd2:    f_seg = 7'h24;
      4'd3:    f_seg = 7'h30;
      4'd4:    f_seg = 7'h19;
      4'd5:    f_seg = 7'h12;
      4'd6:    f_seg = 7'h02;
      4'd7:    f_seg = 7'h78;
      4'd8:    f_seg = 7'h00;
      4'd9:    f_seg = 7'h10;
      default: f_seg = 7'h7F;
    endcase
  endfunction

  assign w_start_edge = start & ~r_start_q;
  assign w_lap_edge   = lap & ~r_lap_q;
  // A start edge restarts the prescaler, so it also suppresses a same-cycle increment.
  assign w_inc        = r_run & (r_tick == TICK_LAST) & ~w_start_edge;
  assign w_disp       = r_hold ? r_snap : r_count;
  assign w_digit      = w_disp[r_idx];
  assign w_blank_sel  = w_blank[r_idx];

  // Ripple-carry BCD increment across all digits in one cycle.
  always_comb begin
    w_count_nxt = r_count;
    w_carry     = w_inc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry) begin
        if (r_count[i] == 4'd9) begin
          w_count_nxt[i] = 4'd0;
        end else begin
          w_count_nxt[i] = r_count[i] + 4'd1;
          w_carry        = 1'b0;
        end
      end
    end
    w_wrap = w_carry;
  end

  // Blank a digit above the decimal point when it and everything above it is zero.
  always_comb begin
    w_lz    = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_lz       = w_lz & (w_disp[i] == 4'd0);
      w_blank[i] = (BLANK_LZ != 0) && (i > DP_POS) && w_lz;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_start_q <= 1'b0;
      r_lap_q   <= 1'b0;
      r_run     <= 1'b0;
      r_hold    <= 1'b0;
      r_ovf     <= 1'b0;
      r_tick    <= '0;
      r_ref     <= '0;
      r_idx     <= '0;
      r_count   <= '0;
      r_snap    <= '0;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_an      <= '1;
    end else begin
      r_start_q <= start;
      r_lap_q   <= lap;

      if (w_start_edge) begin
        r_run  <= ~r_run;
        r_tick <= '0;
      end else if (r_run) begin
        r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + TW'(1);
      end

      r_count <= w_count_nxt;
      if (w_wrap) r_ovf <= 1'b1;

      // Lap decisions use the run/hold state from before this cycle's edges.
      if (w_lap_edge) begin
        if (r_hold) begin
          r_hold <= 1'b0;
        end else if (r_run) begin
          r_hold <= 1'b1;
          r_snap <= r_count;
        end
      end

      if (r_ref == REF_LAST) begin
        r_ref <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
        r_ref <= r_ref + RW'(1);
      end

      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_blank_sel ? 7'h7F : f_seg(w_digit);
      r_dp  <= (r_idx != DP_IDX);
    end
  end

  assign seg      = r_seg;
  assign decimal  = r_dp;
  assign an       = r_an;
  assign overflow = r_ovf;
  assign running  = r_run;

endmodule

// File: tb/tb_stopwatch_scan_driver.sv
// Directed bench for stopwatch_scan_driver: reset, scan order, start/stop timing,
// BCD rollover, overflow, lap hold and coincident start/lap edges.
module tb_stopwatch_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       lap;
  logic [6:0] seg;
  logic       decimal;
  logic [3:0] an;
  logic       running;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [27:0] got_seg;
  logic [3:0]  got_dp;
  localparam logic [3:0] DP_EXP = 4'b1011;

  stopwatch_scan_driver #(
    .NUM_DIGITS (4),
    .TICK_DIV   (4),
    .REFRESH_DIV(2),
    .DP_POS     (2),
    .BLANK_LZ   (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .lap     (lap),
    .seg     (seg),
    .decimal (decimal),
    .an      (an),
    .running (running),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {digit3..digit0} segment patterns for a 4-digit value, DP at digit 2.
  function automatic logic [27:0] exp_disp(input int val);
    logic [27:0] r;
    logic        lz;
    int          dv;
    int          d;
    r  = '0;
    lz = 1'b1;
    dv = 1000;
    for (int i = 3; i >= 0; i--) begin
      d  = (val / dv) % 10;
      dv = dv / 10;
      lz = lz & (d == 0);
      r[i*7 +: 7] = (i > 2 && lz) ? 7'h7F : seg_of(d);
    end
    return r;
  endfunction

  // Capture one full scan (8 clocks); digits never seen stay X.
  task automatic read_display(output logic [27:0] segs, output logic [3:0] dps);
    logic [3:0] one;
    one  = 4'b0001;
    segs = 'x;
    dps  = 'x;
    repeat (8) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (an == 4'(~(one << i))) begin
          segs[i*7 +: 7] = seg;
          dps[i]         = decimal;
        end
      end
    end
  endtask

  // Start edge at E0, stop edge at Ek; count advances by (k-1)/4.
  task automatic run_cycles(input int k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k - 1) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         idx;
    one   = 4'b0001;
    reset = 1'b0;
    start = 1'b0;
    lap   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({an, seg, decimal} !== {4'hF, 7'h7F, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_pins: got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1", an, seg, decimal);
      end
    end
    n_checks++;
    if ({running, overflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got run=%b ovf=%b want 0 0", running, overflow);
    end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idx   = k / 2;
      e_an  = 4'(~(one << idx));
      e_seg = (idx == 3) ? 7'h7F : 7'h40;
      e_dp  = (idx != 2);
      n_checks++;
      if ({an, seg, decimal} !== {e_an, e_seg, e_dp}) begin
        n_fail++;
        $display("FAIL scan_%0d: got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 k, an, seg, decimal, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_start_stop();
    start = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_held: got running=%b want 1", running);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL stop: got running=%b want 0", running);
    end
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(3), DP_EXP}) begin
      n_fail++;
      $display("FAIL count_12cyc: got %h want %h", {got_seg, got_dp}, {exp_disp(3), DP_EXP});
    end
    repeat (20) @(negedge clk);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(3), DP_EXP}) begin
      n_fail++;
      $display("FAIL stopped_hold: got %h want %h", {got_seg, got_dp}, {exp_disp(3), DP_EXP});
    end
    run_cycles(4);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(3), DP_EXP}) begin
      n_fail++;
      $display("FAIL stop_at_tc: got %h want %h", {got_seg, got_dp}, {exp_disp(3), DP_EXP});
    end
    run_cycles(5);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(4), DP_EXP}) begin
      n_fail++;
      $display("FAIL first_tick_4cyc: got %h want %h", {got_seg, got_dp}, {exp_disp(4), DP_EXP});
    end
  endtask

  task automatic test_rollover();
    run_cycles(381);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(99), DP_EXP}) begin
      n_fail++;
      $display("FAIL count_0099: got %h want %h", {got_seg, got_dp}, {exp_disp(99), DP_EXP});
    end
    run_cycles(5);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(100), DP_EXP}) begin
      n_fail++;
      $display("FAIL count_0100: got %h want %h", {got_seg, got_dp}, {exp_disp(100), DP_EXP});
    end
    run_cycles(3601);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {7'h79, 7'h40, 7'h40, 7'h40, DP_EXP}) begin
      n_fail++;
      $display("FAIL count_1000: got %h want %h", {got_seg, got_dp}, {7'h79, 7'h40, 7'h40, 7'h40, DP_EXP});
    end
  endtask

  task automatic test_overflow();
    run_cycles(35997);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp, overflow} !== {exp_disp(9999), DP_EXP, 1'b0}) begin
      n_fail++;
      $display("FAIL count_9999: got %h ovf=%b want %h ovf=0", {got_seg, got_dp}, overflow, {exp_disp(9999), DP_EXP});
    end
    run_cycles(5);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp, overflow} !== {exp_disp(0), DP_EXP, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap: got %h ovf=%b want %h ovf=1", {got_seg, got_dp}, overflow, {exp_disp(0), DP_EXP});
    end
    run_cycles(9);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp, overflow} !== {exp_disp(2), DP_EXP, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %h ovf=%b want %h ovf=1", {got_seg, got_dp}, overflow, {exp_disp(2), DP_EXP});
    end
  endtask

  task automatic test_lap();
    run_cycles(161);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp, running} !== {exp_disp(42), DP_EXP, 1'b1}) begin
      n_fail++;
      $display("FAIL lap_frozen_run: got %h run=%b want %h run=1", {got_seg, got_dp}, running, {exp_disp(42), DP_EXP});
    end
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp, running} !== {exp_disp(42), DP_EXP, 1'b0}) begin
      n_fail++;
      $display("FAIL lap_frozen_stop: got %h run=%b want %h run=0", {got_seg, got_dp}, running, {exp_disp(42), DP_EXP});
    end
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    @(negedge clk);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(52), DP_EXP}) begin
      n_fail++;
      $display("FAIL lap_release: got %h want %h", {got_seg, got_dp}, {exp_disp(52), DP_EXP});
    end
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    @(negedge clk);
    run_cycles(9);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(54), DP_EXP}) begin
      n_fail++;
      $display("FAIL lap_ignored_stopped: got %h want %h", {got_seg, got_dp}, {exp_disp(54), DP_EXP});
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    start = 1'b1;
    lap   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lap   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_run: got running=%b want 0", running);
    end
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(55), DP_EXP}) begin
      n_fail++;
      $display("FAIL b2b_snapshot: got %h want %h", {got_seg, got_dp}, {exp_disp(55), DP_EXP});
    end
    run_cycles(9);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(55), DP_EXP}) begin
      n_fail++;
      $display("FAIL b2b_hold_kept: got %h want %h", {got_seg, got_dp}, {exp_disp(55), DP_EXP});
    end
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    @(negedge clk);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(57), DP_EXP}) begin
      n_fail++;
      $display("FAIL b2b_live: got %h want %h", {got_seg, got_dp}, {exp_disp(57), DP_EXP});
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({an, seg, decimal, running, overflow} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrun_reset: got an=%b seg=%h dp=%b run=%b ovf=%b want 1111 7f 1 0 0",
               an, seg, decimal, running, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp} !== {exp_disp(0), DP_EXP}) begin
      n_fail++;
      $display("FAIL post_reset_zero: got %h want %h", {got_seg, got_dp}, {exp_disp(0), DP_EXP});
    end
    run_cycles(5);
    read_display(got_seg, got_dp);
    n_checks++;
    if ({got_seg, got_dp, overflow} !== {exp_disp(1), DP_EXP, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_hold_clear: got %h ovf=%b want %h ovf=0", {got_seg, got_dp}, overflow, {exp_disp(1), DP_EXP});
    end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_rollover();
    test_overflow();
    test_lap();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
